// File: rtl/sprite_pkg.sv
// Shared sprite types and constants: texel colour, screen coordinate, transparent key.
// Pure declarations, no logic.
package sprite_pkg;

  localparam int DEF_COORD_W = 10;
  localparam int H_RES       = 640;
  localparam int V_RES       = 480;

  typedef logic [11:0]            rgb_t;
  typedef logic [DEF_COORD_W-1:0] coord_t;

  localparam rgb_t TRANSPARENT = 12'h0F0;

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational sprite hit test and SRAM texel address for one pixel coordinate.
// Zero latency, no backpressure.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 32,
  parameter int NUM_FRAMES  = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int COORD_W     = 10
) (
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            pix_x,
  input  logic [COORD_W-1:0]            pix_y,
  input  logic [COORD_W-1:0]            pos_x,
  input  logic [COORD_W-1:0]            pos_y,
  input  logic [$clog2(NUM_FRAMES)-1:0] frame,
  output logic                          hit,
  output logic [ADDR_WIDTH-1:0]         addr
);

  localparam int                     TX_W     = $clog2(SPR_W);
  localparam logic [COORD_W:0]       X_LIM    = (COORD_W+1)'(SPR_W << SCALE_SHIFT);
  localparam logic [COORD_W:0]       Y_LIM    = (COORD_W+1)'(SPR_H << SCALE_SHIFT);
  localparam logic [ADDR_WIDTH-1:0]  FRAME_SZ = ADDR_WIDTH'(SPR_W * SPR_H);

  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;
  logic [COORD_W:0] tx;
  logic [COORD_W:0] ty;

  // One extra bit keeps left/above-of-sprite pixels negative, so clipping never wraps.
  always_comb begin
    dx   = {1'b0, pix_x} - {1'b0, pos_x};
    dy   = {1'b0, pix_y} - {1'b0, pos_y};
    tx   = dx >> SCALE_SHIFT;
    ty   = dy >> SCALE_SHIFT;
    hit  = pix_valid && !dx[COORD_W] && !dy[COORD_W] && (dx < X_LIM) && (dy < Y_LIM);
    addr = ADDR_WIDTH'(frame) * FRAME_SZ + (ADDR_WIDTH'(ty) << TX_W) + ADDR_WIDTH'(tx);
  end

endmodule

// File: rtl/sprite_fetch.sv
// Sprite overlay stage: hit test, SRAM read, compose sprite texel over background.
// 3-cycle latency, one pixel per clock, no backpressure.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 13,
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 32,
  parameter int NUM_FRAMES  = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int COORD_W     = 10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          pix_valid_i,
  input  logic [COORD_W-1:0]            pix_x_i,
  input  logic [COORD_W-1:0]            pix_y_i,
  input  logic [DATA_WIDTH-1:0]         bg_rgb_i,
  input  logic                          frame_start_i,
  input  logic [COORD_W-1:0]            pos_x_i,
  input  logic [COORD_W-1:0]            pos_y_i,
  input  logic [$clog2(NUM_FRAMES)-1:0] frame_idx_i,
  output logic                          sram_en_o,
  output logic [ADDR_WIDTH-1:0]         sram_addr_o,
  input  logic [DATA_WIDTH-1:0]         sram_data_i,
  output logic                          rgb_valid_o,
  output logic [DATA_WIDTH-1:0]         rgb_o,
  output logic                          hit_o
);

  localparam int FRAME_W = $clog2(NUM_FRAMES);

  logic [COORD_W-1:0]    pos_x_q;
  logic [COORD_W-1:0]    pos_y_q;
  logic [FRAME_W-1:0]    frame_q;

  logic                  hit;
  logic [ADDR_WIDTH-1:0] addr;

  logic                  s1_valid;
  logic                  s1_hit;
  logic [DATA_WIDTH-1:0] s1_bg;
  logic                  s2_valid;
  logic                  s2_hit;
  logic [DATA_WIDTH-1:0] s2_bg;

  sprite_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .NUM_FRAMES (NUM_FRAMES),
    .SCALE_SHIFT(SCALE_SHIFT),
    .COORD_W    (COORD_W)
  ) u_addr_gen (
    .pix_valid(pix_valid_i),
    .pix_x    (pix_x_i),
    .pix_y    (pix_y_i),
    .pos_x    (pos_x_q),
    .pos_y    (pos_y_q),
    .frame    (frame_q),
    .hit      (hit),
    .addr     (addr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      frame_q     <= '0;
      sram_en_o   <= 1'b0;
      sram_addr_o <= '0;
      s1_valid    <= 1'b0;
      s1_hit      <= 1'b0;
      s1_bg       <= '0;
      s2_valid    <= 1'b0;
      s2_hit      <= 1'b0;
      s2_bg       <= '0;
      rgb_valid_o <= 1'b0;
      rgb_o       <= '0;
      hit_o       <= 1'b0;
    end else begin
      // Shadow registers update after this cycle's pixel has used the old values.
      if (frame_start_i) begin
        pos_x_q <= pos_x_i;
        pos_y_q <= pos_y_i;
        frame_q <= (32'(frame_idx_i) >= NUM_FRAMES) ? '0 : frame_idx_i;
      end

      sram_en_o   <= hit;
      sram_addr_o <= addr;
      s1_valid    <= pix_valid_i;
      s1_hit      <= hit;
      s1_bg       <= bg_rgb_i;

      s2_valid    <= s1_valid;
      s2_hit      <= s1_hit;
      s2_bg       <= s1_bg;

      // SRAM data is only trusted when this pixel actually issued the read.
      rgb_valid_o <= s2_valid;
      if (s2_valid && s2_hit && (sram_data_i != DATA_WIDTH'(TRANSPARENT))) begin
        rgb_o <= sram_data_i;
        hit_o <= 1'b1;
      end else begin
        rgb_o <= s2_valid ? s2_bg : '0;
        hit_o <= 1'b0;
      end
    end
  end

endmodule
